id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 31 +++
 rtl/id_ex_stage_hazard_detect.sv | 15 +
 rtl/id_ex_stage.sv | 130 +++++++++++++
 tb/tb_id_ex_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths,
// FSM state encoding, ALU operation codes and the packed control bundle.
package id_ex_stage_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_NOR = 4'hC;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds either
// source of the instruction in ID. Register 0 never creates a dependency.
module hazard_detect #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rt,
  output logic                      hazard
);

  assign hazard = ex_mem_read && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall FSM, flush-driven bubbles and
// a saturating stall counter. One cycle from ID inputs to EX outputs.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int          DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int          REG_ADDR_WIDTH   = REG_ADDR_WIDTH_DEF,
  parameter logic [15:0] STALL_COUNT_INIT = 16'h0000
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [DATA_WIDTH-1:0]     ReadData1,
  input  logic [DATA_WIDTH-1:0]     ReadData2,
  input  logic [DATA_WIDTH-1:0]     PCPlus4,
  input  logic [DATA_WIDTH-1:0]     SignExtImm,
  input  logic [REG_ADDR_WIDTH-1:0] Rs,
  input  logic [REG_ADDR_WIDTH-1:0] Rt,
  input  logic [REG_ADDR_WIDTH-1:0] Rd,
  input  logic                      RegWrite,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic                      MemToReg,
  input  logic                      ALUSrc,
  input  logic                      RegDst,
  input  logic                      Branch,
  input  logic [3:0]                ALUOp,
  input  logic                      Flush,
  output logic                      PCWrite,
  output logic                      IFIDWrite,
  output logic [DATA_WIDTH-1:0]     EX_ReadData1,
  output logic [DATA_WIDTH-1:0]     EX_ReadData2,
  output logic [DATA_WIDTH-1:0]     EX_PCPlus4,
  output logic [DATA_WIDTH-1:0]     EX_SignExtImm,
  output logic [REG_ADDR_WIDTH-1:0] EX_Rs,
  output logic [REG_ADDR_WIDTH-1:0] EX_Rt,
  output logic [REG_ADDR_WIDTH-1:0] EX_Rd,
  output logic                      EX_RegWrite,
  output logic                      EX_MemRead,
  output logic                      EX_MemWrite,
  output logic                      EX_MemToReg,
  output logic                      EX_ALUSrc,
  output logic                      EX_RegDst,
  output logic                      EX_Branch,
  output logic [3:0]                EX_ALUOp,
  output logic [15:0]               StallCount
);

  state_t state;
  ctrl_t  ctrl_in;
  ctrl_t  ex_ctrl;
  logic   hazard_raw;
  logic   hazard;
  logic   bubble;
  logic   stall;

  assign ctrl_in.reg_write  = RegWrite;
  assign ctrl_in.mem_read   = MemRead;
  assign ctrl_in.mem_write  = MemWrite;
  assign ctrl_in.mem_to_reg = MemToReg;
  assign ctrl_in.alu_src    = ALUSrc;
  assign ctrl_in.reg_dst    = RegDst;
  assign ctrl_in.branch     = Branch;
  assign ctrl_in.alu_op     = ALUOp;

  hazard_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_hazard_detect (
    .ex_mem_read(ex_ctrl.mem_read),
    .ex_rt      (EX_Rt),
    .rs         (Rs),
    .rt         (Rt),
    .hazard     (hazard_raw)
  );

  // In BUBBLE the EX slot already holds the inserted NOP, so no second stall.
  assign hazard    = hazard_raw && (state == RUN);
  assign stall     = hazard && !Flush;
  assign bubble    = hazard || Flush;
  assign PCWrite   = Rst || !stall;
  assign IFIDWrite = Rst || !stall;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= RUN;
      ex_ctrl       <= '0;
      EX_ReadData1  <= '0;
      EX_ReadData2  <= '0;
      EX_PCPlus4    <= '0;
      EX_SignExtImm <= '0;
      EX_Rs         <= '0;
      EX_Rt         <= '0;
      EX_Rd         <= '0;
      StallCount    <= STALL_COUNT_INIT;
    end else begin
      state <= stall ? BUBBLE : RUN;
      if (bubble) begin
        ex_ctrl       <= '0;
        EX_ReadData1  <= '0;
        EX_ReadData2  <= '0;
        EX_PCPlus4    <= '0;
        EX_SignExtImm <= '0;
        EX_Rs         <= '0;
        EX_Rt         <= '0;
        EX_Rd         <= '0;
      end else begin
        ex_ctrl       <= ctrl_in;
        EX_ReadData1  <= ReadData1;
        EX_ReadData2  <= ReadData2;
        EX_PCPlus4    <= PCPlus4;
        EX_SignExtImm <= SignExtImm;
        EX_Rs         <= Rs;
        EX_Rt         <= Rt;
        EX_Rd         <= Rd;
      end
      if (stall && (StallCount != 16'hFFFF)) begin
        StallCount <= StallCount + 16'd1;
      end
    end
  end

  assign EX_RegWrite = ex_ctrl.reg_write;
  assign EX_MemRead  = ex_ctrl.mem_read;
  assign EX_MemWrite = ex_ctrl.mem_write;
  assign EX_MemToReg = ex_ctrl.mem_to_reg;
  assign EX_ALUSrc   = ex_ctrl.alu_src;
  assign EX_RegDst   = ex_ctrl.reg_dst;
  assign EX_Branch   = ex_ctrl.branch;
  assign EX_ALUOp    = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents and stall counts are
// queued as each ID instruction is driven and compared after the capturing edge.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [15:0] SAT_INIT = 16'hFFFD;

  typedef struct packed {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] pc4;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    ctrl_t         ctrl;
  } ex_t;

  typedef struct {
    ex_t         ex;
    logic [15:0] cnt;
    logic [15:0] cnt_sat;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst;
  logic Flush;
  ex_t  id;

  logic          PCWrite, IFIDWrite;
  logic [DW-1:0] EX_ReadData1, EX_ReadData2, EX_PCPlus4, EX_SignExtImm;
  logic [AW-1:0] EX_Rs, EX_Rt, EX_Rd;
  logic          EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_RegDst, EX_Branch;
  logic [3:0]    EX_ALUOp;
  logic [15:0]   StallCount;

  logic          s_PCWrite, s_IFIDWrite;
  logic [DW-1:0] s_ReadData1, s_ReadData2, s_PCPlus4, s_SignExtImm;
  logic [AW-1:0] s_Rs, s_Rt, s_Rd;
  logic          s_RegWrite, s_MemRead, s_MemWrite, s_MemToReg, s_ALUSrc, s_RegDst, s_Branch;
  logic [3:0]    s_ALUOp;
  logic [15:0]   s_StallCount;

  ex_t obs;
  assign obs = {EX_ReadData1, EX_ReadData2, EX_PCPlus4, EX_SignExtImm, EX_Rs, EX_Rt, EX_Rd,
                EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_RegDst,
                EX_Branch, EX_ALUOp};

  always #5 Clk = ~Clk;

  id_ex_stage dut (
    .Clk(Clk), .Rst(Rst),
    .ReadData1(id.rd1), .ReadData2(id.rd2), .PCPlus4(id.pc4), .SignExtImm(id.imm),
    .Rs(id.rs), .Rt(id.rt), .Rd(id.rd),
    .RegWrite(id.ctrl.reg_write), .MemRead(id.ctrl.mem_read), .MemWrite(id.ctrl.mem_write),
    .MemToReg(id.ctrl.mem_to_reg), .ALUSrc(id.ctrl.alu_src), .RegDst(id.ctrl.reg_dst),
    .Branch(id.ctrl.branch), .ALUOp(id.ctrl.alu_op), .Flush(Flush),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_PCPlus4(EX_PCPlus4),
    .EX_SignExtImm(EX_SignExtImm), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemToReg(EX_MemToReg), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
    .EX_Branch(EX_Branch), .EX_ALUOp(EX_ALUOp), .StallCount(StallCount)
  );

  // Second instance starts its counter near the top so saturation is reachable quickly.
  id_ex_stage #(.STALL_COUNT_INIT(SAT_INIT)) dut_sat (
    .Clk(Clk), .Rst(Rst),
    .ReadData1(id.rd1), .ReadData2(id.rd2), .PCPlus4(id.pc4), .SignExtImm(id.imm),
    .Rs(id.rs), .Rt(id.rt), .Rd(id.rd),
    .RegWrite(id.ctrl.reg_write), .MemRead(id.ctrl.mem_read), .MemWrite(id.ctrl.mem_write),
    .MemToReg(id.ctrl.mem_to_reg), .ALUSrc(id.ctrl.alu_src), .RegDst(id.ctrl.reg_dst),
    .Branch(id.ctrl.branch), .ALUOp(id.ctrl.alu_op), .Flush(Flush),
    .PCWrite(s_PCWrite), .IFIDWrite(s_IFIDWrite),
    .EX_ReadData1(s_ReadData1), .EX_ReadData2(s_ReadData2), .EX_PCPlus4(s_PCPlus4),
    .EX_SignExtImm(s_SignExtImm), .EX_Rs(s_Rs), .EX_Rt(s_Rt), .EX_Rd(s_Rd),
    .EX_RegWrite(s_RegWrite), .EX_MemRead(s_MemRead), .EX_MemWrite(s_MemWrite),
    .EX_MemToReg(s_MemToReg), .EX_ALUSrc(s_ALUSrc), .EX_RegDst(s_RegDst),
    .EX_Branch(s_Branch), .EX_ALUOp(s_ALUOp), .StallCount(s_StallCount)
  );

  int checks = 0;
  int errors = 0;

  ex_t         m_ex;
  state_t      m_state;
  logic [15:0] m_cnt;
  logic [15:0] m_cnt_sat;
  exp_t        sb[$];

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ex_t instr(input logic [DW-1:0] rd1, input logic [AW-1:0] rs,
                                input logic [AW-1:0] rt, input logic mr, input logic [3:0] op);
    ex_t t;
    t.rd1 = rd1;
    t.rd2 = ~rd1;
    t.pc4 = 32'h0000_1000 + rd1;
    t.imm = 32'hFFFF_FFF0;
    t.rs  = rs;
    t.rt  = rt;
    t.rd  = rs ^ rt ^ 5'd1;
    t.ctrl.reg_write  = 1'b1;
    t.ctrl.mem_read   = mr;
    t.ctrl.mem_write  = 1'b0;
    t.ctrl.mem_to_reg = mr;
    t.ctrl.alu_src    = mr;
    t.ctrl.reg_dst    = ~mr;
    t.ctrl.branch     = 1'b0;
    t.ctrl.alu_op     = op;
    return t;
  endfunction

  function automatic void model_reset();
    m_ex      = '0;
    m_state   = RUN;
    m_cnt     = 16'h0000;
    m_cnt_sat = SAT_INIT;
    sb.delete();
  endfunction

  // Called at a negedge: drives one ID instruction, checks stall enables, then the capture.
  task automatic step(input ex_t s, input logic fl);
    exp_t e;
    logic haz;
    id    = s;
    Flush = fl;
    #1;
    haz = m_ex.ctrl.mem_read && (m_ex.rt != '0) && ((m_ex.rt == s.rs) || (m_ex.rt == s.rt))
          && (m_state == RUN);
    chk("pcwrite", PCWrite, fl || !haz);
    chk("ifidwrite", IFIDWrite, fl || !haz);
    e.ex = (fl || haz) ? ex_t'('0) : s;
    e.cnt = m_cnt;
    e.cnt_sat = m_cnt_sat;
    if (haz && !fl) begin
      if (e.cnt != 16'hFFFF) e.cnt = e.cnt + 16'd1;
      if (e.cnt_sat != 16'hFFFF) e.cnt_sat = e.cnt_sat + 16'd1;
    end
    m_state   = (haz && !fl) ? BUBBLE : RUN;
    m_ex      = e.ex;
    m_cnt     = e.cnt;
    m_cnt_sat = e.cnt_sat;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk("ex_fields", obs, e.ex);
    chk("stall_count", StallCount, e.cnt);
    chk("stall_count_sat", s_StallCount, e.cnt_sat);
    @(negedge Clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ex"}, obs, '0);
    chk({tag, "_cnt"}, StallCount, 16'h0000);
    chk({tag, "_cnt_sat"}, s_StallCount, SAT_INIT);
    chk({tag, "_pcwrite"}, PCWrite, 1'b1);
    chk({tag, "_ifidwrite"}, IFIDWrite, 1'b1);
  endtask

  initial begin
    ex_t r;
    Rst   = 1'b1;
    Flush = 1'b0;
    id    = '0;
    model_reset();
    #1;
    check_reset_state("reset");
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    // Normal flow
    step(instr(32'h0000_1234, 5'd3, 5'd4, 1'b0, ALU_ADD), 1'b0);
    chk("ex_readdata1", EX_ReadData1, 32'h0000_1234);
    chk("ex_rs", EX_Rs, 5'd3);
    chk("ex_regwrite", EX_RegWrite, 1'b1);
    chk("ex_aluop", EX_ALUOp, 4'h2);

    // Load-use: lw into r8, dependent instruction held one cycle then passes
    step(instr(32'h0000_0100, 5'd1, 5'd8, 1'b1, ALU_ADD), 1'b0);
    step(instr(32'h0000_0200, 5'd8, 5'd2, 1'b0, ALU_SUB), 1'b0);
    chk("stall_one", StallCount, 16'd1);
    step(instr(32'h0000_0200, 5'd8, 5'd2, 1'b0, ALU_SUB), 1'b0);
    chk("passed_rs", EX_Rs, 5'd8);

    // Zero register never stalls
    step(instr(32'h0000_0300, 5'd0, 5'd0, 1'b1, ALU_ADD), 1'b0);
    step(instr(32'h0000_0400, 5'd0, 5'd0, 1'b0, ALU_OR), 1'b0);
    chk("zero_reg_cnt", StallCount, 16'd1);

    // Flush coinciding with a hazard
    step(instr(32'h0000_0500, 5'd2, 5'd5, 1'b1, ALU_ADD), 1'b0);
    step(instr(32'h0000_0600, 5'd7, 5'd5, 1'b0, ALU_AND), 1'b1);
    chk("flush_cnt", StallCount, 16'd1);

    // Repeated stalls drive the second counter into saturation
    for (int i = 0; i < 4; i++) begin
      step(instr(32'h0000_0700 + i, 5'd1, 5'd9, 1'b1, ALU_ADD), 1'b0);
      step(instr(32'h0000_0800 + i, 5'd9, 5'd9, 1'b0, ALU_SLT), 1'b0);
      step(instr(32'h0000_0800 + i, 5'd9, 5'd9, 1'b0, ALU_SLT), 1'b0);
    end
    chk("sat_cnt", s_StallCount, 16'hFFFF);

    // Reset during a stall abandons it
    step(instr(32'h0000_0900, 5'd1, 5'd6, 1'b1, ALU_ADD), 1'b0);
    id    = instr(32'h0000_0A00, 5'd6, 5'd3, 1'b0, ALU_NOR);
    Flush = 1'b0;
    @(posedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    check_reset_state("reset_stall");
    model_reset();
    @(negedge Clk);
    Rst = 1'b0;
    step(instr(32'h0000_0A00, 5'd6, 5'd3, 1'b0, ALU_NOR), 1'b0);

    // Random traffic with a small register range to hit hazards often
    for (int i = 0; i < 40; i++) begin
      r = instr($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      r.imm              = $urandom;
      r.ctrl.mem_write   = 1'($urandom_range(0, 1));
      r.ctrl.branch      = 1'($urandom_range(0, 1));
      step(r, ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset pulse mid-cycle after a live instruction
    step(instr(32'hDEAD_BEEF, 5'd4, 5'd5, 1'b0, ALU_ADD), 1'b0);
    #2;
    Rst = 1'b1;
    #1;
    check_reset_state("reset_mid");
    #1;
    Rst = 1'b0;
    model_reset();
    @(negedge Clk);
    step(instr(32'h0000_5678, 5'd2, 5'd3, 1'b0, ALU_ADD), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
